// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with split-transaction parking and release priority.
// Define ARB_TIMEOUT_EN to add a watchdog that ends a grant after TIMEOUT busy cycles.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int SLAVE_LEN   = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_MASTERS-1:0]             request,
    input  logic [NUM_MASTERS*SLAVE_LEN-1:0]   slave_sel,
    input  logic                               trans_done,
    input  logic                               split,
    input  logic [NUM_SLAVES-1:0]              split_release,
    output logic [NUM_MASTERS-1:0]             grant,
    output logic [$clog2(NUM_MASTERS)-1:0]     owner,
    output logic [SLAVE_LEN-1:0]               sel_slave,
    output logic                               arbiter_busy,
    output logic                               bus_busy,
    output logic [NUM_MASTERS-1:0]             split_pending
);

    localparam int PTR_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || NUM_SLAVES > 2**SLAVE_LEN || TIMEOUT < 1) begin : g_param_check
        $error("bus_arbiter_rr: illegal parameter combination");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [SLAVE_LEN-1:0]   parked_slave [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] release_prio;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] prio_cand;
    logic [NUM_MASTERS-1:0] release_hit;
    logic [NUM_MASTERS-1:0] park_set;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [NUM_MASTERS-1:0] release_prio_next;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       rr_next;
    logic [SLAVE_LEN-1:0]   win_slave;
    logic                   found;
    logic                   done_path;
    logic                   split_path;
    logic                   timeout_hit;
    int                     idx;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_count;
    assign timeout_hit = (wd_count >= WD_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    assign eligible  = request & ~split_pending;
    assign prio_cand = eligible & release_prio;

    // Recently released masters go first, otherwise scan upward from rr_ptr.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && prio_cand[i]) begin
                found   = 1'b1;
                win_idx = PTR_W'(i);
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    assign win_slave  = slave_sel[int'(win_idx)*SLAVE_LEN +: SLAVE_LEN];
    assign grant_next = found ? (NUM_MASTERS'(1) << win_idx) : '0;
    assign rr_next    = (owner == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

    // trans_done (or watchdog) beats a simultaneous split.
    assign done_path  = (state == BUSY) && (trans_done || timeout_hit);
    assign split_path = (state == BUSY) && split && !done_path;

    always_comb begin
        release_hit = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (split_release[s] && parked_slave[i] == SLAVE_LEN'(s)) begin
                    release_hit[i] = 1'b1;
                end
            end
        end
    end

    assign park_set = split_path ? (NUM_MASTERS'(1) << owner) : '0;

    // Priority lasts only while the released master keeps requesting and is not yet served.
    always_comb begin
        release_prio_next = (release_prio | (split_pending & release_hit)) & request & ~park_set;
        if (state == IDLE) begin
            release_prio_next = release_prio_next & ~grant_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            grant         <= '0;
            owner         <= '0;
            sel_slave     <= '0;
            arbiter_busy  <= 1'b0;
            bus_busy      <= 1'b0;
            split_pending <= '0;
            rr_ptr        <= '0;
            release_prio  <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                parked_slave[i] <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            wd_count      <= '0;
`endif
        end else begin
            // A park set in this cycle survives a release aimed at the same slave.
            split_pending <= (split_pending & ~release_hit) | park_set;
            release_prio  <= release_prio_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        state        <= BUSY;
                        grant        <= grant_next;
                        owner        <= win_idx;
                        sel_slave    <= win_slave;
                        arbiter_busy <= 1'b1;
                        bus_busy     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        wd_count     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (done_path || split_path) begin
                        state        <= IDLE;
                        grant        <= '0;
                        arbiter_busy <= 1'b0;
                        bus_busy     <= 1'b0;
                        rr_ptr       <= rr_next;
                        if (split_path) begin
                            parked_slave[owner] <= sel_slave;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        wd_count <= wd_count + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, default 4, SHALL set the number of requesting masters (2..8).
REQ-002 Parameter SLAVE_LEN, default 2, SHALL set the width of each slave-select field.
REQ-003 Parameter NUM_SLAVES, default 3, SHALL set the number of slaves (≤ 2**SLAVE_LEN).
REQ-004 Parameter TIMEOUT, default 64, SHALL set the watchdog limit in clock cycles.
REQ-005 Port clk  input  1  SHALL be the single system clock; all logic rising-edge.
REQ-006 Port reset  input  1  SHALL be the reset; synchronous and active-low.
REQ-007 Port request  input  NUM_MASTERS  SHALL be the per-master bus request.
REQ-008 Port slave_sel  input  NUM_MASTERS*SLAVE_LEN  SHALL be the per-master target slave; master i uses bits [i*SLAVE_LEN +: SLAVE_LEN].
REQ-009 Port trans_done  input  1  SHALL be the transaction-complete pulse from the current owner.
REQ-010 Port split  input  1  SHALL be the split request from the currently addressed slave.
REQ-011 Port split_release  input  NUM_SLAVES  SHALL be the per-slave "ready to resume" pulse.
REQ-012 Port grant  output  NUM_MASTERS  SHALL be a one-hot-or-zero grant.
REQ-013 Port owner  output  $clog2(NUM_MASTERS)  SHALL be the index of the granted master.
REQ-014 Port sel_slave  output  SLAVE_LEN  SHALL be the slave latched at grant time.
REQ-015 Port arbiter_busy  output  1  SHALL be high whenever any grant is asserted.
REQ-016 Port bus_busy  output  1  SHALL be high in BUSY state while trans_done is not yet seen.
REQ-017 Port split_pending  output  NUM_MASTERS  SHALL flag masters parked by a split.

Function
REQ-018 States SHALL be IDLE and BUSY only.
REQ-019 Eligible set = request AND NOT split_pending; in IDLE with eligible non-empty, the block SHALL enter BUSY next cycle with grant/owner/sel_slave registered (1-cycle latency).
REQ-020 Winner SHALL be the first eligible master scanning from rr_ptr upward, wrapping at NUM_MASTERS-1 → 0.
REQ-021 Exception: a master released from split in the current or earlier cycle and still requesting SHALL win over rr_ptr order (lowest index among such masters).
REQ-022 sel_slave SHALL be captured from the winner's slave_sel field at grant and held constant in BUSY.
REQ-023 In BUSY, grant SHALL hold until trans_done, split, or timeout, even if request drops.
REQ-024 On trans_done in BUSY: next cycle IDLE, grant=0, rr_ptr = owner+1 (wrapping).
REQ-025 On split in BUSY: next cycle IDLE, grant=0, split_pending[owner]=1, parked slave id stored per master, rr_ptr = owner+1.
REQ-026 trans_done and split in the same cycle: trans_done SHALL win; no park.
REQ-027 split_release[s] SHALL clear split_pending for every master parked on slave s, effective next cycle.
REQ-028 split and split_release for the same slave in the same cycle: the newly parked master SHALL stay parked; only earlier-parked masters are released.
REQ-029 trans_done/split/split_release in IDLE SHALL be ignored except for release-clearing (REQ-027).
REQ-030 Back-to-back: re-arbitration SHALL occur only from IDLE, giving a minimum one idle cycle between grants.

Reset
REQ-031 On reset low at a clock edge: state=IDLE, grant=0, owner=0, sel_slave=0, arbiter_busy=0, bus_busy=0, split_pending=0, rr_ptr=0, watchdog=0.
REQ-032 Reset mid-BUSY SHALL drop grant at that edge with no trans_done required.

Configuration
REQ-033 Macro ARB_TIMEOUT_EN defined: a counter SHALL increment each BUSY cycle, clear on entry to BUSY, and on reaching TIMEOUT force the trans_done path (REQ-024) next cycle.
REQ-034 Macro ARB_TIMEOUT_EN undefined: no counter SHALL exist; BUSY ends only by trans_done, split, or reset.

Verification
REQ-035 Reset low 2 cycles, request=4'b0000 → all outputs 0, state IDLE.
REQ-036 request=4'b1010 held, trans_done pulsed 3 cycles after each grant → grants in order 4'b0010, 4'b1000, 4'b0010 with one idle cycle between.
REQ-037 Master 0 granted, slave_sel=2'd1, split pulsed → grant=0, split_pending=4'b0001; request=4'b0011 → master 1 granted; split_release=3'b010 then trans_done → master 0 granted next.
REQ-038 Same-cycle trans_done and split while owner=2 → split_pending stays 4'b0000, rr_ptr=3.
REQ-039 ARB_TIMEOUT_EN, TIMEOUT=8, master 3 granted, no trans_done → grant drops exactly 9 cycles after grant; without macro grant stays high 100 cycles.
REQ-040 Reset asserted during BUSY with owner=1 → grant=0, split_pending=0 on the following edge.
